instruction_decoder: RTL and testbench
======================================

# instruction_decoder

Control-side decoder consuming the 16-bit instruction word and the A/B status flags (Z, C, N) produced upstream. It accepts one instruction per handshake and latches it along with the flags. It then sequences the resulting memory, register-load, ALU and jump strobes over one or more cycles. It sits between the instruction source and the 8-bit datapath/1024-word memory, driving the memory's write-enable, address, read enable and read-to-A/B selects.

## Interface
- No parameters; widths are fixed: instruction 16, data 8, address 10.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- iValid  input  1  instruction word present on iInstruction.
- iInstruction  input  16  [15:12] opcode, [11] reg select (0=A, 1=B), [10] unused, [9:0] address / immediate field.
- iZa, iZb, iCa, iCb, iNa, iNb  input  1 each  zero/carry/negative flags of registers A and B.
- oReady  output  1  decoder can accept an instruction this cycle.
- oWriteEnable  output  1  memory write strobe.
- oReadEnable  output  1  memory read request.
- oReadToA, oReadToB  output  1 each  load memory read data into A / B.
- oAddress  output  10  memory address or jump target.
- oImmediate  output  8  immediate value (iInstruction[7:0]).
- oImmLoad  output  1  load oImmediate into the selected register.
- oRegSel  output  1  latched reg select bit.
- oAluEn  output  1  ALU operation strobe.
- oAluOp  output  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- oJump  output  1  jump taken, target on oAddress.
- oDone  output  1  one-cycle pulse on the last cycle of every instruction.
- oHalt  output  1  decoder halted.
- oIllegal  output  1  undefined opcode, pulse with oDone.

## Operation
- Opcode map:
  - 0000 NOP, 0001 LD, 0010 ST, 0011 LDI.
  - 0100–0111 ALU (oAluOp = opcode[1:0]).
  - 1000 JMP, 1001 JZ, 1010 JC, 1011 JN, 1100 HALT.
  - 1101–1111 illegal.
- States: IDLE, EXEC, RD_REQ, RD_WAIT, RD_LOAD, HALT.
- IDLE: oReady=1. On iValid&oReady the decoder latches the instruction and all six flags at the same edge. It then goes to RD_REQ for LD, HALT for HALT, and EXEC for everything else. With iValid=0 it stays in IDLE.
- EXEC (1 cycle), then IDLE:
  - NOP: only oDone.
  - ST: oWriteEnable=1, oAddress=field.
  - LDI: oImmLoad=1, oImmediate=field[7:0].
  - ALU: oAluEn=1.
  - JMP: oJump=1.
  - Jcc: oJump = latched flag of the selected register (Z/C/N); oAddress=field whether taken or not.
  - Illegal: oIllegal=1, no strobes.
  - oDone=1 in every case.
- RD_REQ → RD_WAIT → RD_LOAD → IDLE:
  - oReadEnable=1 and oAddress=field in RD_REQ and RD_WAIT.
  - RD_LOAD drives oReadToA (sel=0) or oReadToB (sel=1) plus oDone.
- HALT: oHalt=1 and oReady=0 until reset. oDone pulses on the first HALT cycle only.
- oRegSel, oAddress and oImmediate hold their latched values outside strobe cycles. Strobe outputs are 0 in every state not listed above.

## Timing
- All outputs are registered or Moore-decoded from the state register and instruction latch; there is no combinational input-to-output path.
- Reset value of every output is 0, and oReady is 0 while reset is high. State goes to IDLE, so oReady=1 on the first edge after reset is released.
- Latency from the accept edge:
  - Single-cycle ops: strobes and oDone in the next cycle.
  - LD: oReadEnable in cycles +1 and +2, oReadToA/B and oDone in cycle +3.
- Throughput: one EXEC instruction per 2 cycles, one LD per 4 cycles.
- iInstruction and the flags are ignored while oReady=0. Changes to the flags after the accept edge do not affect a pending jump.
- Reset asserted mid-LD or mid-EXEC: outputs are cleared immediately (asynchronously), and the in-flight instruction is dropped with no oDone.
- iValid held high continuously: a new instruction is accepted on every IDLE cycle.

## Test plan
- Reset release → all outputs 0, oReady=1 on the first cycle; NOP (0x0000) accepted → next cycle oDone=1 only.
- ST 0x200A (addr 10) → one cycle later oWriteEnable=1, oAddress=10, oDone=1; back-to-back LDI 0x3808 accepted two cycles after the first accept → oImmLoad=1, oRegSel=1, oImmediate=8.
- LD 0x101F (A, addr 31) → oReadEnable=1 for 2 cycles with oAddress=31, then oReadToA=1 with oDone=1; repeat with 0x1BFF → oReadToB=1, oAddress=1023.
- JZ 0x9840 (reg B) with iZb=1 at accept, then iZb dropped next cycle → oJump=1, oAddress=0x040. With iZb=0 at accept → oJump=0, oDone=1.
- Opcode 0xE000 → oIllegal=1 and oDone=1 for one cycle, no other strobes; HALT 0xC000 → oHalt=1, oReady=0 held for ≥10 cycles regardless of iValid.
- Reset pulsed during RD_WAIT of an LD → oReadEnable falls without waiting for a clock edge, no oReadToA/oReadToB or oDone pulse, IDLE after release.

Source files
------------

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - multi-cycle control decoder for the 8-bit datapath / 1024-word memory
//
// Accepts one 16-bit instruction per handshake (iValid & oReady), latches it
// together with the A/B flags, then sequences memory, register-load, ALU and
// jump strobes. Every output is decoded from the state register and the
// instruction/flag latches only.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   iValid, iInstruction[15:0] instruction handshake and word
//   iZa iZb iCa iCb iNa iNb    zero/carry/negative flags of registers A and B
//   oReady                     decoder accepts an instruction this cycle
//   oWriteEnable, oReadEnable  memory write / read strobes
//   oReadToA, oReadToB         load memory read data into A / B
//   oAddress[9:0]              memory address or jump target (latched field)
//   oImmediate[7:0], oImmLoad  immediate value and its load strobe
//   oRegSel                    latched register select
//   oAluEn, oAluOp[1:0]        ALU strobe and operation
//   oJump                      jump taken
//   oDone, oHalt, oIllegal     last-cycle pulse, halted, undefined opcode

module instruction_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        iValid,
    input  logic [15:0] iInstruction,
    input  logic        iZa,
    input  logic        iZb,
    input  logic        iCa,
    input  logic        iCb,
    input  logic        iNa,
    input  logic        iNb,
    output logic        oReady,
    output logic        oWriteEnable,
    output logic        oReadEnable,
    output logic        oReadToA,
    output logic        oReadToB,
    output logic [9:0]  oAddress,
    output logic [7:0]  oImmediate,
    output logic        oImmLoad,
    output logic        oRegSel,
    output logic        oAluEn,
    output logic [1:0]  oAluOp,
    output logic        oJump,
    output logic        oDone,
    output logic        oHalt,
    output logic        oIllegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_LOAD,
        S_HALT
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [3:0]  opcode;
    logic        sel;
    logic [9:0]  field;
    logic        za, zb, ca, cb, na, nb;
    logic        live;       // low until the first edge after reset, keeps oReady low during reset
    logic        halt_seen;  // set after the first HALT cycle so oDone pulses only once
    logic        accept;
    logic        unused_bit;

    assign unused_bit = iInstruction[10];
    assign accept     = iValid & oReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            opcode    <= 4'd0;
            sel       <= 1'b0;
            field     <= 10'd0;
            {za, zb, ca, cb, na, nb} <= 6'd0;
            live      <= 1'b0;
            halt_seen <= 1'b0;
        end else begin
            state <= next_state;
            live  <= 1'b1;
            if (accept) begin
                opcode <= iInstruction[15:12];
                sel    <= iInstruction[11];
                field  <= iInstruction[9:0];
                {za, zb, ca, cb, na, nb} <= {iZa, iZb, iCa, iCb, iNa, iNb};
            end
            if (state == S_HALT) begin
                halt_seen <= 1'b1;
            end
        end
    end

    // Next state looks at the incoming opcode because the latch only updates at the accept edge.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (iInstruction[15:12])
                        4'b0001: next_state = S_RD_REQ;
                        4'b1100: next_state = S_HALT;
                        default: next_state = S_EXEC;
                    endcase
                end
            end
            S_EXEC:    next_state = S_IDLE;
            S_RD_REQ:  next_state = S_RD_WAIT;
            S_RD_WAIT: next_state = S_RD_LOAD;
            S_RD_LOAD: next_state = S_IDLE;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        oReady       = 1'b0;
        oWriteEnable = 1'b0;
        oReadEnable  = 1'b0;
        oReadToA     = 1'b0;
        oReadToB     = 1'b0;
        oImmLoad     = 1'b0;
        oAluEn       = 1'b0;
        oJump        = 1'b0;
        oDone        = 1'b0;
        oHalt        = 1'b0;
        oIllegal     = 1'b0;
        oAddress     = field;
        oImmediate   = field[7:0];
        oRegSel      = sel;
        oAluOp       = opcode[1:0];
        case (state)
            S_IDLE: oReady = live;
            S_EXEC: begin
                oDone = 1'b1;
                casez (opcode)
                    4'b0010: oWriteEnable = 1'b1;
                    4'b0011: oImmLoad     = 1'b1;
                    4'b01??: oAluEn       = 1'b1;
                    4'b1000: oJump        = 1'b1;
                    4'b1001: oJump        = sel ? zb : za;
                    4'b1010: oJump        = sel ? cb : ca;
                    4'b1011: oJump        = sel ? nb : na;
                    4'b1101, 4'b1110, 4'b1111: oIllegal = 1'b1;
                    default: ;
                endcase
            end
            S_RD_REQ, S_RD_WAIT: oReadEnable = 1'b1;
            S_RD_LOAD: begin
                oReadToA = ~sel;
                oReadToB = sel;
                oDone    = 1'b1;
            end
            S_HALT: begin
                oHalt = 1'b1;
                oDone = ~halt_seen;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - scoreboard bench for instruction_decoder

module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iValid = 1'b0;
    logic [15:0] iInstruction = 16'h0000;
    logic        iZa = 1'b0, iZb = 1'b0, iCa = 1'b0, iCb = 1'b0, iNa = 1'b0, iNb = 1'b0;
    logic        oReady, oWriteEnable, oReadEnable, oReadToA, oReadToB;
    logic [9:0]  oAddress;
    logic [7:0]  oImmediate;
    logic        oImmLoad, oRegSel, oAluEn;
    logic [1:0]  oAluOp;
    logic        oJump, oDone, oHalt, oIllegal;

    instruction_decoder dut (
        .clk(clk), .reset(reset), .iValid(iValid), .iInstruction(iInstruction),
        .iZa(iZa), .iZb(iZb), .iCa(iCa), .iCb(iCb), .iNa(iNa), .iNb(iNb),
        .oReady(oReady), .oWriteEnable(oWriteEnable), .oReadEnable(oReadEnable),
        .oReadToA(oReadToA), .oReadToB(oReadToB), .oAddress(oAddress),
        .oImmediate(oImmediate), .oImmLoad(oImmLoad), .oRegSel(oRegSel),
        .oAluEn(oAluEn), .oAluOp(oAluOp), .oJump(oJump), .oDone(oDone),
        .oHalt(oHalt), .oIllegal(oIllegal)
    );

    always #5 clk = ~clk;

    // strobe vector: {we, re, rta, rtb, immload, aluen, jump, done, halt, illegal}
    localparam logic [9:0] S_WE   = 10'b1000000000;
    localparam logic [9:0] S_RE   = 10'b0100000000;
    localparam logic [9:0] S_RTA  = 10'b0010000000;
    localparam logic [9:0] S_RTB  = 10'b0001000000;
    localparam logic [9:0] S_IMM  = 10'b0000100000;
    localparam logic [9:0] S_ALU  = 10'b0000010000;
    localparam logic [9:0] S_JMP  = 10'b0000001000;
    localparam logic [9:0] S_DONE = 10'b0000000100;
    localparam logic [9:0] S_HALT = 10'b0000000010;
    localparam logic [9:0] S_ILL  = 10'b0000000001;

    typedef struct {
        string      name;
        logic [9:0] strobes;
        logic [9:0] addr;
        logic [7:0] imm;
        logic       sel;
        logic [1:0] aluop;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    function automatic logic [9:0] dut_strobes();
        return {oWriteEnable, oReadEnable, oReadToA, oReadToB, oImmLoad,
                oAluEn, oJump, oDone, oHalt, oIllegal};
    endfunction

    task automatic expect_out(input string n, input logic [9:0] s, input logic [9:0] a,
                              input logic [7:0] im, input logic sl, input logic [1:0] op);
        exp_t e;
        e.name = n; e.strobes = s; e.addr = a; e.imm = im; e.sel = sl; e.aluop = op;
        exp_q.push_back(e);
    endtask

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", n, got, want);
        end
    endtask

    // Monitor: any strobe other than the held oHalt marks an output cycle to score.
    always @(negedge clk) begin
        if (!reset && ((dut_strobes() & ~S_HALT) != 10'd0)) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output: strobes=%b addr=%h with empty scoreboard",
                         dut_strobes(), oAddress);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (dut_strobes() !== e.strobes || oAddress !== e.addr ||
                    oImmediate !== e.imm || oRegSel !== e.sel ||
                    ((e.strobes & S_ALU) != 10'd0 && oAluOp !== e.aluop)) begin
                    mismatched++;
                    $display("FAIL %s: got strobes=%b addr=%h imm=%h sel=%b op=%b, expected strobes=%b addr=%h imm=%h sel=%b op=%b",
                             e.name, dut_strobes(), oAddress, oImmediate, oRegSel, oAluOp,
                             e.strobes, e.addr, e.imm, e.sel, e.aluop);
                end
            end
        end
    end

    // Issue one instruction; flags after the accept edge are inverted and the word
    // garbled to show that only the accept-edge values matter.
    task automatic issue(input logic [15:0] ins, input logic [5:0] fl);
        int n = 0;
        while (!oReady && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!oReady) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: oReady=%b after %0d cycles, expected 1", oReady, n);
        end else begin
            iValid = 1'b1;
            iInstruction = ins;
            {iZa, iZb, iCa, iCb, iNa, iNb} = fl;
            @(posedge clk); #1;
            iValid = 1'b0;
            iInstruction = 16'hFFFF;
            {iZa, iZb, iCa, iCb, iNa, iNb} = ~fl;
        end
    endtask

    initial begin
        #3;
        check("reset_strobes", {22'd0, dut_strobes()}, 32'd0);
        check("reset_ready", {31'd0, oReady}, 32'd0);
        check("reset_addr", {22'd0, oAddress}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", {31'd0, oReady}, 32'd1);
        check("idle_strobes", {22'd0, dut_strobes()}, 32'd0);

        expect_out("nop", S_DONE, 10'd0, 8'h00, 1'b0, 2'b00);
        issue(16'h0000, 6'b000000);

        expect_out("st", S_WE | S_DONE, 10'd10, 8'h0A, 1'b0, 2'b00);
        issue(16'h200A, 6'b000000);
        expect_out("ldi", S_IMM | S_DONE, 10'd8, 8'h08, 1'b1, 2'b00);
        issue(16'h3808, 6'b000000);

        expect_out("ld_a_req", S_RE, 10'd31, 8'h1F, 1'b0, 2'b00);
        expect_out("ld_a_wait", S_RE, 10'd31, 8'h1F, 1'b0, 2'b00);
        expect_out("ld_a_load", S_RTA | S_DONE, 10'd31, 8'h1F, 1'b0, 2'b00);
        issue(16'h101F, 6'b000000);
        expect_out("ld_b_req", S_RE, 10'd1023, 8'hFF, 1'b1, 2'b11);
        expect_out("ld_b_wait", S_RE, 10'd1023, 8'hFF, 1'b1, 2'b11);
        expect_out("ld_b_load", S_RTB | S_DONE, 10'd1023, 8'hFF, 1'b1, 2'b11);
        issue(16'h1BFF, 6'b000000);

        // flags order {Za, Zb, Ca, Cb, Na, Nb}
        expect_out("jz_b_taken", S_JMP | S_DONE, 10'h040, 8'h40, 1'b1, 2'b01);
        issue(16'h9840, 6'b010000);
        expect_out("jz_b_not_taken", S_DONE, 10'h040, 8'h40, 1'b1, 2'b01);
        issue(16'h9840, 6'b100000);
        expect_out("jc_a_taken", S_JMP | S_DONE, 10'h005, 8'h05, 1'b0, 2'b10);
        issue(16'hA005, 6'b001000);
        expect_out("jn_b_not_taken", S_DONE, 10'h005, 8'h05, 1'b1, 2'b11);
        issue(16'hB805, 6'b000010);
        expect_out("jmp", S_JMP | S_DONE, 10'h3FF, 8'hFF, 1'b0, 2'b00);
        issue(16'h83FF, 6'b000000);
        expect_out("alu_sub", S_ALU | S_DONE, 10'h003, 8'h03, 1'b1, 2'b01);
        issue(16'h5803, 6'b000000);
        expect_out("alu_or", S_ALU | S_DONE, 10'h005, 8'h05, 1'b0, 2'b11);
        issue(16'h7005, 6'b000000);
        expect_out("illegal", S_ILL | S_DONE, 10'h000, 8'h00, 1'b0, 2'b10);
        issue(16'hE000, 6'b111111);

        // Reset during RD_WAIT of an LD drops the load.
        expect_out("ld_rst_req", S_RE, 10'h005, 8'h05, 1'b0, 2'b01);
        expect_out("ld_rst_wait", S_RE, 10'h005, 8'h05, 1'b0, 2'b01);
        issue(16'h1005, 6'b000000);
        @(posedge clk);
        @(negedge clk); #1;
        check("rd_wait_read_enable", {31'd0, oReadEnable}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_read_enable", {31'd0, oReadEnable}, 32'd0);
        check("async_reset_strobes", {22'd0, dut_strobes()}, 32'd0);
        check("async_reset_ready", {31'd0, oReady}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_mid_ld_reset", {31'd0, oReady}, 32'd1);

        expect_out("halt", S_HALT | S_DONE, 10'h000, 8'h00, 1'b0, 2'b00);
        issue(16'hC000, 6'b000000);
        @(posedge clk); #1;
        iValid = 1'b1;
        iInstruction = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            check("halt_held", {29'd0, oHalt, oReady, oDone}, {29'd0, 3'b100});
            @(posedge clk); #1;
        end
        iValid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
